// File: rtl/fifo_hex_uart_tx.sv
// Pops 4-bit samples from a show-ahead FIFO and sends each as an ASCII hex character over 8N1 UART.
// Define HEX_UART_CRLF_EN to follow every hex character with CR and LF frames.
module fifo_hex_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned COUNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [3:0]             fifo_data,
    output logic                   fifo_pop,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done,
    output logic [COUNT_WIDTH-1:0] char_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef HEX_UART_CRLF_EN
        STOP,
        SEL_NEXT
`else
        STOP
`endif
    } state_t;

    state_t                 state_q;
    logic [BAUD_W-1:0]      baud_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic                   tx_q;
    logic                   pop_q;
    logic                   busy_q;
    logic                   done_q;
    logic [COUNT_WIDTH-1:0] count_q;
`ifdef HEX_UART_CRLF_EN
    logic [1:0]             grp_q;
`endif

    logic can_start;
    logic bit_end;

    assign can_start = enable && !fifo_empty;
    assign bit_end   = (baud_q == BAUD_LAST);

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // The pop decision is registered one cycle ahead so that fifo_pop and busy
    // rise together in the pop cycle; the head is captured as that cycle ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
`ifdef HEX_UART_CRLF_EN
            grp_q   <= '0;
`endif
        end else begin
            pop_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (pop_q) begin
                        shift_q <= hex_ascii(fifo_data);
                        tx_q    <= 1'b0;
                        state_q <= START;
`ifdef HEX_UART_CRLF_EN
                        grp_q   <= '0;
`endif
                    end else begin
                        pop_q  <= can_start;
                        busy_q <= can_start;
                        tx_q   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
`ifdef HEX_UART_CRLF_EN
                        if (grp_q != 2'd2) begin
                            state_q <= SEL_NEXT;
                        end else begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            count_q <= count_q + COUNT_WIDTH'(1);
                            pop_q   <= can_start;
                            busy_q  <= can_start;
                        end
`else
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        count_q <= count_q + COUNT_WIDTH'(1);
                        pop_q   <= can_start;
                        busy_q  <= can_start;
`endif
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`ifdef HEX_UART_CRLF_EN
                // Single tx-high gap cycle that loads CR, then LF, without popping.
                SEL_NEXT: begin
                    baud_q  <= '0;
                    shift_q <= (grp_q == 2'd0) ? 8'h0D : 8'h0A;
                    grp_q   <= grp_q + 2'd1;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_pop   = pop_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign char_count = count_q;

endmodule
